// File: rtl/mm_arb_pkg.sv
// Shared encodings and helpers for the two-master round-robin MM bus arbiter.
package mm_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // Counter load for an access of 'cycles' bus cycles; out-of-range values clamp to 1..16.
    function automatic logic [CNT_W-1:0] access_cnt_load(input int cycles);
        if (cycles <= 1) begin
            return '0;
        end else if (cycles >= 16) begin
            return '1;
        end else begin
            return CNT_W'(cycles - 1);
        end
    endfunction

endpackage

// File: rtl/mm_arbiter_rr_if.sv
// Requester handshakes plus slave bus of the MM arbiter; 'slave' is the arbiter's view.
interface mm_arbiter_rr_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              m0_req_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_wdata_i;
    logic              m0_we_i;
    logic [DATA_W-1:0] m0_rdata_o;
    logic              m0_ack_o;

    logic              m1_req_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_wdata_i;
    logic              m1_we_i;
    logic [DATA_W-1:0] m1_rdata_o;
    logic              m1_ack_o;

    logic [ADDR_W-1:0] mm_m_addr_o;
    logic [DATA_W-1:0] mm_m_wdata_o;
    logic              mm_m_we_o;
    logic [DATA_W-1:0] mm_m_rdata_i;

    logic              arb_busy_o;
    logic              arb_owner_o;

    modport slave (
        input  m0_req_i, m0_addr_i, m0_wdata_i, m0_we_i,
        input  m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i,
        input  mm_m_rdata_i,
        output m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o,
        output mm_m_addr_o, mm_m_wdata_o, mm_m_we_o,
        output arb_busy_o, arb_owner_o
    );

    modport master (
        output m0_req_i, m0_addr_i, m0_wdata_i, m0_we_i,
        output m1_req_i, m1_addr_i, m1_wdata_i, m1_we_i,
        output mm_m_rdata_i,
        input  m0_rdata_o, m0_ack_o, m1_rdata_o, m1_ack_o,
        input  mm_m_addr_o, mm_m_wdata_o, mm_m_we_o,
        input  arb_busy_o, arb_owner_o
    );

endinterface

// File: rtl/mm_arb_rr_pick.sv
// Combinational 2-way round-robin pick: a lone requester wins, a tie goes to the non-last owner.
module mm_arb_rr_pick
    import mm_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic       o_gnt_valid_c,
    output logic       o_gnt_idx_c
);

    always_comb begin
        o_gnt_valid_c = |i_req;
        o_gnt_idx_c   = OWNER_M0;
        if (i_req == 2'b11) begin
            o_gnt_idx_c = ~i_last_owner;
        end else if (i_req[1]) begin
            o_gnt_idx_c = OWNER_M1;
        end
    end

endmodule

// File: rtl/mm_arbiter_rr.sv
// Two-master round-robin arbiter for the single-cycle MM slave bus.
// Each grant latches the owner's request and runs a fixed-length access, then acks once.
module mm_arbiter_rr
    import mm_arb_pkg::*;
#(
    parameter int unsigned MM_ADDR_WIDTH = 8,
    parameter int unsigned MM_DATA_WIDTH = 16,
    parameter int          ACCESS_CYCLES = 1
) (
    input  logic           clk_sys_i,
    input  logic           rst_n_i,
    mm_arbiter_rr_if.slave mm_if
);

    localparam logic [CNT_W-1:0] CNT_LOAD = access_cnt_load(ACCESS_CYCLES);

    state_t                   r_state,      w_state_nxt;
    logic [CNT_W-1:0]         r_cnt,        w_cnt_nxt;
    logic                     r_owner,      w_owner_nxt;
    logic                     r_last_owner, w_last_owner_nxt;
    logic [MM_ADDR_WIDTH-1:0] r_addr,       w_addr_nxt;
    logic [MM_DATA_WIDTH-1:0] r_wdata,      w_wdata_nxt;
    logic                     r_we,         w_we_nxt;
    logic                     r_strobe,     w_strobe_nxt;
    logic                     r_busy,       w_busy_nxt;
    logic [MM_DATA_WIDTH-1:0] r_m0_rdata,   w_m0_rdata_nxt;
    logic [MM_DATA_WIDTH-1:0] r_m1_rdata,   w_m1_rdata_nxt;
    logic                     r_m0_ack,     w_m0_ack_nxt;
    logic                     r_m1_ack,     w_m1_ack_nxt;

    logic                     w_gnt_valid;
    logic                     w_gnt_idx;
    logic [MM_ADDR_WIDTH-1:0] w_sel_addr;
    logic [MM_DATA_WIDTH-1:0] w_sel_wdata;
    logic                     w_sel_we;

    mm_arb_rr_pick u_pick (
        .i_req         ({mm_if.m1_req_i, mm_if.m0_req_i}),
        .i_last_owner  (r_last_owner),
        .o_gnt_valid_c (w_gnt_valid),
        .o_gnt_idx_c   (w_gnt_idx)
    );

    // Next-state and registered-output logic; the write strobe is pre-computed one cycle ahead.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_we_nxt         = r_we;
        w_strobe_nxt     = 1'b0;
        w_m0_rdata_nxt   = r_m0_rdata;
        w_m1_rdata_nxt   = r_m1_rdata;
        w_m0_ack_nxt     = 1'b0;
        w_m1_ack_nxt     = 1'b0;

        w_sel_addr  = mm_if.m0_addr_i;
        w_sel_wdata = mm_if.m0_wdata_i;
        w_sel_we    = mm_if.m0_we_i;
        if (w_gnt_idx == OWNER_M1) begin
            w_sel_addr  = mm_if.m1_addr_i;
            w_sel_wdata = mm_if.m1_wdata_i;
            w_sel_we    = mm_if.m1_we_i;
        end

        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) begin
                    w_state_nxt      = ST_ACCESS;
                    w_owner_nxt      = w_gnt_idx;
                    w_last_owner_nxt = w_gnt_idx;
                    w_addr_nxt       = w_sel_addr;
                    w_wdata_nxt      = w_sel_wdata;
                    w_we_nxt         = w_sel_we;
                    w_cnt_nxt        = CNT_LOAD;
                    w_strobe_nxt     = (CNT_LOAD == '0) && w_sel_we;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_DONE;
                    if (r_owner == OWNER_M1) begin
                        w_m1_rdata_nxt = mm_if.mm_m_rdata_i;
                        w_m1_ack_nxt   = 1'b1;
                    end else begin
                        w_m0_rdata_nxt = mm_if.mm_m_rdata_i;
                        w_m0_ack_nxt   = 1'b1;
                    end
                end else begin
                    w_cnt_nxt    = r_cnt - CNT_W'(1);
                    w_strobe_nxt = (r_cnt == CNT_W'(1)) && r_we;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_owner      <= OWNER_M0;
            r_last_owner <= OWNER_M1;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_strobe     <= 1'b0;
            r_busy       <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_we         <= w_we_nxt;
            r_strobe     <= w_strobe_nxt;
            r_busy       <= w_busy_nxt;
            r_m0_rdata   <= w_m0_rdata_nxt;
            r_m1_rdata   <= w_m1_rdata_nxt;
            r_m0_ack     <= w_m0_ack_nxt;
            r_m1_ack     <= w_m1_ack_nxt;
        end
    end

    assign mm_if.mm_m_addr_o  = r_addr;
    assign mm_if.mm_m_wdata_o = r_wdata;
    assign mm_if.mm_m_we_o    = r_strobe;
    assign mm_if.m0_rdata_o   = r_m0_rdata;
    assign mm_if.m1_rdata_o   = r_m1_rdata;
    assign mm_if.m0_ack_o     = r_m0_ack;
    assign mm_if.m1_ack_o     = r_m1_ack;
    assign mm_if.arb_busy_o   = r_busy;
    assign mm_if.arb_owner_o  = r_owner;

endmodule
